// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the program loader and the control decoder:
// mnemonic IDs, opcode/funct fields, loader FSM states, error codes and
// small word-packing helpers.
package mips_isa_pkg;

  // Symbolic mnemonic IDs as delivered by the host; 18..31 are illegal
  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_SUB   = 5'd1,
    MN_AND   = 5'd2,
    MN_OR    = 5'd3,
    MN_XOR   = 5'd4,
    MN_SLT   = 5'd5,
    MN_JR    = 5'd6,
    MN_ADDI  = 5'd7,
    MN_ADDIU = 5'd8,
    MN_ORI   = 5'd9,
    MN_LUI   = 5'd10,
    MN_LW    = 5'd11,
    MN_SW    = 5'd12,
    MN_BEQ   = 5'd13,
    MN_BGEZ  = 5'd14,
    MN_BGTZ  = 5'd15,
    MN_J     = 5'd16,
    MN_JAL   = 5'd17
  } mnem_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // REGIMM rt selector that turns opcode 000001 into bgez
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } ld_state_e;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_FULL    = 2'b10;

  // R-type packing with shamt fixed at zero
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type packing
  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  // J-type packing
  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_load_encoder_if.sv
// Symbolic instruction stream from the host into the loader (valid/ready).
interface instr_load_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        in_last;

  // Host side: drives the instruction, watches ready
  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready
  );

  // Loader side: consumes the instruction, drives ready
  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_word_encode.sv
// Combinational encoder: symbolic instruction fields -> 32-bit MIPS word.
// Unused register fields of special forms are forced to their fixed values.
module instr_word_encode
  import mips_isa_pkg::*;
(
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [15:0] imm16;

  assign imm16 = in_imm[15:0];

  // Select the format and fixed fields from the mnemonic
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (in_mnem)
      MN_ADD:   word = r_word(in_rs, in_rt, in_rd, FN_ADD);
      MN_SUB:   word = r_word(in_rs, in_rt, in_rd, FN_SUB);
      MN_AND:   word = r_word(in_rs, in_rt, in_rd, FN_AND);
      MN_OR:    word = r_word(in_rs, in_rt, in_rd, FN_OR);
      MN_XOR:   word = r_word(in_rs, in_rt, in_rd, FN_XOR);
      MN_SLT:   word = r_word(in_rs, in_rt, in_rd, FN_SLT);
      MN_JR:    word = r_word(in_rs, 5'd0, 5'd0, FN_JR);
      MN_ADDI:  word = i_word(OP_ADDI, in_rs, in_rt, imm16);
      MN_ADDIU: word = i_word(OP_ADDIU, in_rs, in_rt, imm16);
      MN_ORI:   word = i_word(OP_ORI, in_rs, in_rt, imm16);
      MN_LUI:   word = i_word(OP_LUI, 5'd0, in_rt, imm16);
      MN_LW:    word = i_word(OP_LW, in_rs, in_rt, imm16);
      MN_SW:    word = i_word(OP_SW, in_rs, in_rt, imm16);
      MN_BEQ:   word = i_word(OP_BEQ, in_rs, in_rt, imm16);
      MN_BGEZ:  word = i_word(OP_REGIMM, in_rs, RT_BGEZ, imm16);
      MN_BGTZ:  word = i_word(OP_BGTZ, in_rs, 5'd0, imm16);
      MN_J:     word = j_word(OP_J, in_imm);
      MN_JAL:   word = j_word(OP_JAL, in_imm);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_load_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and writes
// them to consecutive IM addresses, then releases the core with cpu_run.
// An illegal mnemonic or running out of IM space parks the block in ERROR.
module instr_load_encoder
  import mips_isa_pkg::*;
#(
  parameter int IM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_load_encoder_if.slave in_if,
  output logic                im_we,
  output logic [IM_AW-1:0]    im_addr,
  output logic [31:0]         im_wdata,
  output logic [IM_AW:0]      word_count,
  output logic                cpu_run,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [IM_AW:0]   COUNT_ONE = {{IM_AW{1'b0}}, 1'b1};
  localparam logic [IM_AW-1:0] LAST_ADDR = {IM_AW{1'b1}};

  ld_state_e   state_reg;
  logic        in_ready_reg;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        at_last_addr;

  instr_word_encode u_encode (
    .in_mnem (in_if.in_mnem),
    .in_rs   (in_if.in_rs),
    .in_rt   (in_if.in_rt),
    .in_rd   (in_if.in_rd),
    .in_imm  (in_if.in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Ready is registered and only high in LOAD, so a terminating word
  // drops it in the same cycle the new state becomes visible.
  assign in_if.in_ready = in_ready_reg;
  assign accept         = in_if.in_valid & in_ready_reg;

  // The word count doubles as the next write address; it never reaches
  // 2^IM_AW while in LOAD, so the low bits alone identify the final slot.
  assign at_last_addr = (word_count[IM_AW-1:0] == LAST_ADDR);

  // Loader FSM with registered handshake, IM write port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      in_ready_reg <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      word_count   <= '0;
      cpu_run      <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      im_we <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            in_ready_reg <= 1'b1;
            im_addr      <= '0;
            word_count   <= '0;
            cpu_run      <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              // Illegal wins over in_last; nothing is written
              state_reg    <= ST_ERROR;
              in_ready_reg <= 1'b0;
              err          <= 1'b1;
              err_code     <= ERR_ILLEGAL;
            end else begin
              im_we      <= 1'b1;
              im_addr    <= word_count[IM_AW-1:0];
              im_wdata   <= enc_word;
              word_count <= word_count + COUNT_ONE;
              if (in_if.in_last) begin
                // A last word fitting the final slot is a clean finish
                state_reg    <= ST_DONE;
                in_ready_reg <= 1'b0;
                cpu_run      <= 1'b1;
              end else if (at_last_addr) begin
                state_reg    <= ST_ERROR;
                in_ready_reg <= 1'b0;
                err          <= 1'b1;
                err_code     <= ERR_FULL;
              end
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_load_encoder.sv
// Self-checking bench for instr_load_encoder: directed scenarios plus
// randomized streams against a table-driven encoding model.
module tb_instr_load_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;

  // Default-size DUT
  instr_load_encoder_if bif ();
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] word_count;
  logic        cpu_run, err;
  logic [1:0]  err_code;

  // Tiny-IM DUT for the full-memory boundary
  instr_load_encoder_if sif ();
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;
  logic        s_run, s_err;
  logic [1:0]  s_code;

  instr_load_encoder #(.IM_AW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_if(bif),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .word_count(word_count),
    .cpu_run(cpu_run), .err(err), .err_code(err_code)
  );

  instr_load_encoder #(.IM_AW(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .in_if(sif),
    .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata), .word_count(s_count),
    .cpu_run(s_run), .err(s_err), .err_code(s_code)
  );

  int tests_run = 0;
  int fails = 0;

  // Reference encoding from the opcode/funct tables and field arithmetic
  function automatic bit [31:0] ref_encode(input int m, input int rs_i, input int rt_i,
                                           input int rd_i, input int unsigned imm, output bit ill);
    int unsigned op_tab[18] = '{0, 0, 0, 0, 0, 0, 0, 8, 9, 13, 15, 35, 43, 4, 1, 7, 2, 3};
    int unsigned fn_tab[7]  = '{32, 34, 36, 37, 38, 42, 8};
    int unsigned rs, rt, rd, w;
    rs = rs_i; rt = rt_i; rd = rd_i;
    ill = (m < 0 || m > 17);
    if (ill) return 32'd0;
    if (m == 6) begin rt = 0; rd = 0; end
    if (m == 10) rs = 0;
    if (m == 14) rt = 1;
    if (m == 15) rt = 0;
    if (m <= 6)
      w = rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + fn_tab[m];
    else if (m <= 15)
      w = op_tab[m] * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + (imm % 32'd65536);
    else
      w = op_tab[m] * 32'd67108864 + (imm % 32'd67108864);
    return w;
  endfunction

  task automatic do_reset();
    bif.in_valid = 0; bif.in_last = 0; bif.in_mnem = 0; bif.in_rs = 0;
    bif.in_rt = 0; bif.in_rd = 0; bif.in_imm = 0;
    sif.in_valid = 0; sif.in_last = 0; sif.in_mnem = 0; sif.in_rs = 0;
    sif.in_rt = 0; sif.in_rd = 0; sif.in_imm = 0;
    start = 0; start_s = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulse_start_s();
    start_s = 1;
    @(negedge clk);
    start_s = 0;
  endtask

  // Present one word and return at the negedge after it was accepted
  task automatic send(input int m, input int rs, input int rt, input int rd,
                      input int unsigned imm, input bit last, output int waited);
    waited = 0;
    bif.in_mnem = 5'(m); bif.in_rs = 5'(rs); bif.in_rt = 5'(rt); bif.in_rd = 5'(rd);
    bif.in_imm = 26'(imm); bif.in_last = last; bif.in_valid = 1;
    while (bif.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      tests_run++; fails++;
      $display("FAIL handshake_timeout got=in_ready %b exp=1 within 40 cycles", bif.in_ready);
      waited = -1;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_s(input int m, input int rs, input int rt, input int rd,
                        input int unsigned imm, input bit last, output int waited);
    waited = 0;
    sif.in_mnem = 5'(m); sif.in_rs = 5'(rs); sif.in_rt = 5'(rt); sif.in_rd = 5'(rd);
    sif.in_imm = 26'(imm); sif.in_last = last; sif.in_valid = 1;
    while (sif.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      tests_run++; fails++;
      $display("FAIL handshake_timeout_s got=in_ready %b exp=1 within 40 cycles", sif.in_ready);
      waited = -1;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bif.in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", bif.in_ready); end
    tests_run++; if (im_we !== 1'b0) begin fails++; $display("FAIL rst_we got=%b exp=0", im_we); end
    tests_run++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL rst_run got=%b exp=0", cpu_run); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", err); end
    tests_run++; if (im_addr !== 10'd0) begin fails++; $display("FAIL rst_addr got=%0d exp=0", im_addr); end
    tests_run++; if (im_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", im_wdata); end
    tests_run++; if (err_code !== 2'b00) begin fails++; $display("FAIL rst_code got=%b exp=00", err_code); end
    tests_run++; if (word_count !== 11'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", word_count); end
    // Start is the only way out of IDLE; stray valid must not write
    bif.in_valid = 1;
    @(negedge clk);
    bif.in_valid = 0;
    tests_run++; if (im_we !== 1'b0 || bif.in_ready !== 1'b0) begin fails++; $display("FAIL idle_valid got=we %b ready %b exp=0 0", im_we, bif.in_ready); end
  endtask

  task automatic test_first_word();
    int w;
    do_reset();
    pulse_start();
    tests_run++; if (bif.in_ready !== 1'b1) begin fails++; $display("FAIL start_ready got=%b exp=1", bif.in_ready); end
    send(0, 1, 2, 3, 0, 0, w);
    bif.in_valid = 0;
    $display("[TB] add   addr=%0d data=%h count=%0d", im_addr, im_wdata, word_count);
    tests_run++; if (im_we !== 1'b1) begin fails++; $display("FAIL add_we got=%b exp=1", im_we); end
    tests_run++; if (im_addr !== 10'd0) begin fails++; $display("FAIL add_addr got=%0d exp=0", im_addr); end
    tests_run++; if (im_wdata !== 32'h00221820) begin fails++; $display("FAIL add_wdata got=%h exp=00221820", im_wdata); end
    tests_run++; if (word_count !== 11'd1) begin fails++; $display("FAIL add_count got=%0d exp=1", word_count); end
    @(negedge clk);
    tests_run++; if (im_we !== 1'b0) begin fails++; $display("FAIL add_pulse got=%b exp=0", im_we); end
    tests_run++; if (im_addr !== 10'd0) begin fails++; $display("FAIL add_hold got=%0d exp=0", im_addr); end
  endtask

  task automatic test_back_to_back();
    int mn[3] = '{10, 12, 14};
    int rs[3] = '{0, 29, 5};
    int rt[3] = '{1, 2, 0};
    int unsigned imm[3] = '{32'h1234, 32'd4, 32'd3};
    bit [31:0] expw[3] = '{32'h3C011234, 32'hAFA20004, 32'h04A10003};
    int w;
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(mn[i], rs[i], rt[i], 0, imm[i], 0, w);
      $display("[TB] b2b   addr=%0d data=%h count=%0d", im_addr, im_wdata, word_count);
      tests_run++; if (w !== 0) begin fails++; $display("FAIL b2b_stall%0d got=%0d exp=0 wait cycles", i, w); end
      tests_run++; if (im_we !== 1'b1) begin fails++; $display("FAIL b2b_we%0d got=%b exp=1", i, im_we); end
      tests_run++; if (im_addr !== 10'(i)) begin fails++; $display("FAIL b2b_addr%0d got=%0d exp=%0d", i, im_addr, i); end
      tests_run++; if (im_wdata !== expw[i]) begin fails++; $display("FAIL b2b_wdata%0d got=%h exp=%h", i, im_wdata, expw[i]); end
      tests_run++; if (word_count !== 11'(i + 1)) begin fails++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, word_count, i + 1); end
    end
    bif.in_valid = 0;
    @(negedge clk);
    tests_run++; if (im_we !== 1'b0 || word_count !== 11'd3) begin fails++; $display("FAIL b2b_end got=we %b count %0d exp=0 3", im_we, word_count); end
  endtask

  task automatic test_jal_last();
    int w;
    do_reset();
    pulse_start();
    send(17, 0, 0, 0, 32'hC00, 1, w);
    bif.in_valid = 0;
    $display("[TB] jal   addr=%0d data=%h count=%0d", im_addr, im_wdata, word_count);
    tests_run++; if (im_we !== 1'b1) begin fails++; $display("FAIL jal_we got=%b exp=1", im_we); end
    tests_run++; if (im_wdata !== 32'h0C000C00) begin fails++; $display("FAIL jal_wdata got=%h exp=0c000c00", im_wdata); end
    tests_run++; if (cpu_run !== 1'b1) begin fails++; $display("FAIL jal_run got=%b exp=1", cpu_run); end
    tests_run++; if (bif.in_ready !== 1'b0) begin fails++; $display("FAIL jal_ready got=%b exp=0", bif.in_ready); end
    tests_run++; if (word_count !== 11'd1) begin fails++; $display("FAIL jal_count got=%0d exp=1", word_count); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL jal_err got=%b exp=0", err); end
  endtask

  task automatic test_illegal();
    int w;
    bit ill;
    bit [31:0] e;
    do_reset();
    pulse_start();
    send(0, 1, 2, 3, 0, 0, w);
    send(9, 4, 5, 0, 32'h00FF, 0, w);
    send(20, 1, 1, 1, 32'h5, 1, w);
    bif.in_valid = 0;
    $display("[TB] ill   we=%b err=%b code=%b count=%0d", im_we, err, err_code, word_count);
    tests_run++; if (im_we !== 1'b0) begin fails++; $display("FAIL ill_we got=%b exp=0", im_we); end
    tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err got=%b exp=1", err); end
    tests_run++; if (err_code !== 2'b01) begin fails++; $display("FAIL ill_code got=%b exp=01", err_code); end
    tests_run++; if (word_count !== 11'd2) begin fails++; $display("FAIL ill_count got=%0d exp=2", word_count); end
    tests_run++; if (cpu_run !== 1'b0 || bif.in_ready !== 1'b0) begin fails++; $display("FAIL ill_state got=run %b ready %b exp=0 0", cpu_run, bif.in_ready); end
    tests_run++; if (im_addr !== 10'd1) begin fails++; $display("FAIL ill_addr_hold got=%0d exp=1", im_addr); end
    // Restart out of ERROR
    pulse_start();
    tests_run++; if (err !== 1'b0 || err_code !== 2'b00 || word_count !== 11'd0 || bif.in_ready !== 1'b1)
      begin fails++; $display("FAIL restart got=err %b code %b count %0d ready %b exp=0 00 0 1", err, err_code, word_count, bif.in_ready); end
    send(4, 7, 8, 9, 0, 1, w);
    bif.in_valid = 0;
    e = ref_encode(4, 7, 8, 9, 0, ill);
    tests_run++; if (im_addr !== 10'd0 || im_wdata !== e || cpu_run !== 1'b1)
      begin fails++; $display("FAIL restart_wr got=addr %0d data %h run %b exp=0 %h 1", im_addr, im_wdata, cpu_run, e); end
  endtask

  task automatic test_full();
    int w, m, rs, rt, rd;
    int unsigned imm;
    bit ill, last;
    bit [31:0] e;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      pulse_start_s();
      for (int i = 0; i < 4; i++) begin
        m = $urandom_range(0, 17); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
        rd = $urandom_range(0, 31); imm = $urandom;
        last = (round == 1 && i == 3);
        e = ref_encode(m, rs, rt, rd, imm, ill);
        send_s(m, rs, rt, rd, imm, last, w);
        $display("[TB] small r%0d addr=%0d data=%h count=%0d", round, s_addr, s_wdata, s_count);
        tests_run++; if (s_we !== 1'b1 || s_addr !== 2'(i) || s_wdata !== e || s_count !== 3'(i + 1))
          begin fails++; $display("FAIL full_wr%0d_%0d got=we %b addr %0d data %h count %0d exp=1 %0d %h %0d", round, i, s_we, s_addr, s_wdata, s_count, i, e, i + 1); end
      end
      sif.in_valid = 0;
      if (round == 0) begin
        tests_run++; if (s_err !== 1'b1 || s_code !== 2'b10 || s_run !== 1'b0 || sif.in_ready !== 1'b0)
          begin fails++; $display("FAIL full_err got=err %b code %b run %b ready %b exp=1 10 0 0", s_err, s_code, s_run, sif.in_ready); end
      end else begin
        tests_run++; if (s_err !== 1'b0 || s_code !== 2'b00 || s_run !== 1'b1 || sif.in_ready !== 1'b0)
          begin fails++; $display("FAIL full_last got=err %b code %b run %b ready %b exp=0 00 1 0", s_err, s_code, s_run, sif.in_ready); end
      end
    end
  endtask

  task automatic test_random();
    int w, m, rs, rt, rd, len, cnt;
    int unsigned imm;
    bit ill, last;
    bit [31:0] e;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      pulse_start();
      tests_run++; if (word_count !== 11'd0 || bif.in_ready !== 1'b1)
        begin fails++; $display("FAIL rnd_start%0d got=count %0d ready %b exp=0 1", s, word_count, bif.in_ready); end
      len = $urandom_range(3, 12);
      cnt = 0;
      for (int i = 0; i < len; i++) begin
        m = ($urandom_range(0, 99) < 10) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        imm = $urandom;
        last = (i == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          bif.in_valid = 0;
          @(negedge clk);
        end
        e = ref_encode(m, rs, rt, rd, imm, ill);
        send(m, rs, rt, rd, imm, last, w);
        $display("[TB] rnd s%0d mnem=%0d we=%b addr=%0d data=%h count=%0d", s, m, im_we, im_addr, im_wdata, word_count);
        if (ill) begin
          tests_run++; if (im_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || word_count !== 11'(cnt))
            begin fails++; $display("FAIL rnd_ill s%0d got=we %b err %b code %b count %0d exp=0 1 01 %0d", s, im_we, err, err_code, word_count, cnt); end
          break;
        end
        tests_run++; if (im_we !== 1'b1 || im_addr !== 10'(cnt) || im_wdata !== e || word_count !== 11'(cnt + 1))
          begin fails++; $display("FAIL rnd_wr s%0d i%0d got=we %b addr %0d data %h count %0d exp=1 %0d %h %0d", s, i, im_we, im_addr, im_wdata, word_count, cnt, e, cnt + 1); end
        cnt++;
        if (last) begin
          tests_run++; if (cpu_run !== 1'b1 || err !== 1'b0)
            begin fails++; $display("FAIL rnd_done s%0d got=run %b err %b exp=1 0", s, cpu_run, err); end
        end
      end
      bif.in_valid = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midload();
    int w;
    do_reset();
    pulse_start();
    send(1, 3, 4, 5, 0, 0, w);
    send(7, 6, 7, 0, 32'h8000, 0, w);
    bif.in_valid = 0;
    // start while loading has no effect
    pulse_start();
    tests_run++; if (word_count !== 11'd2 || bif.in_ready !== 1'b1)
      begin fails++; $display("FAIL start_in_load got=count %0d ready %b exp=2 1", word_count, bif.in_ready); end
    send(11, 29, 8, 0, 32'h10, 0, w);
    tests_run++; if (im_addr !== 10'd2 || im_we !== 1'b1)
      begin fails++; $display("FAIL mid_addr got=addr %0d we %b exp=2 1", im_addr, im_we); end
    #2 rst = 0;
    #1;
    bif.in_valid = 0;
    $display("[TB] rst   we=%b count=%0d ready=%b", im_we, word_count, bif.in_ready);
    tests_run++; if (word_count !== 11'd0 || im_we !== 1'b0 || bif.in_ready !== 1'b0 || im_addr !== 10'd0)
      begin fails++; $display("FAIL async_rst got=count %0d we %b ready %b addr %0d exp=0 0 0 0", word_count, im_we, bif.in_ready, im_addr); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests_run++; if (bif.in_ready !== 1'b0 || cpu_run !== 1'b0 || err !== 1'b0)
      begin fails++; $display("FAIL post_rst_idle got=ready %b run %b err %b exp=0 0 0", bif.in_ready, cpu_run, err); end
    pulse_start();
    send(3, 1, 1, 2, 0, 1, w);
    bif.in_valid = 0;
    tests_run++; if (im_addr !== 10'd0 || word_count !== 11'd1 || im_wdata !== 32'h00211025)
      begin fails++; $display("FAIL reload got=addr %0d count %0d data %h exp=0 1 00211025", im_addr, word_count, im_wdata); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_jal_last();
    test_illegal();
    test_full();
    test_random();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
